// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that turns fetch and data requests into fixed-length memory accesses.
// Optional alignment faulting is compiled in with `define MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic [1:0]  if_size,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    // ACCESS is the only state with both bits set, and every legal transition into or
    // out of it moves the bits monotonically, so the mem_en/mem_rw decode cannot glitch.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b11,
        DONE   = 2'b10
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state, state_next;
    port_t       last_grant, grant_q, grant_sel;
    logic        req_any;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_fault;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_ext;
    logic [1:0]  size_q;
    logic        rw_q;
    logic        done_if, done_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        req_any   = if_req | d_req;
        grant_sel = PORT_D;
        if (if_req && (!d_req || last_grant == PORT_D))
            grant_sel = PORT_IF;
        sel_addr = (grant_sel == PORT_IF) ? if_addr : d_addr;
        sel_size = (grant_sel == PORT_IF) ? if_size : d_size;
        if (sel_size == 2'b11)
            sel_size = SZ_BYTE;
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign sel_fault = ((sel_size == SZ_HALF) && sel_addr[0]) ||
                       ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
`else
    assign sel_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = sel_fault ? DONE : SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_HALF: rdata_ext = {16'b0, mem_rdata[15:0]};
            SZ_WORD: rdata_ext = mem_rdata;
            default: rdata_ext = {24'b0, mem_rdata[7:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= PORT_D;
            grant_q    <= PORT_IF;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_BYTE;
            rw_q       <= 1'b1;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    grant_q <= grant_sel;
                    addr_q  <= sel_addr;
                    size_q  <= sel_size;
                    rw_q    <= (grant_sel == PORT_IF) ? 1'b1 : d_rw;
                    wdata_q <= (grant_sel == PORT_IF) ? 32'h0 : d_wdata;
                    rdata_q <= '0;
                end
                SETUP:  cnt_q <= CNT_LOAD;
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (rw_q)
                            rdata_q <= rdata_ext;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE:    last_grant <= grant_q;
                default: ;
            endcase
        end
    end

    assign done_if = (state == DONE) && (grant_q == PORT_IF);
    assign done_d  = (state == DONE) && (grant_q == PORT_D);

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (reset)
            fault_q <= 1'b0;
        else if (state == IDLE && req_any)
            fault_q <= sel_fault;
    end

    assign if_fault = done_if & fault_q;
    assign d_fault  = done_d & fault_q;
`else
    assign if_fault = 1'b0;
    assign d_fault  = 1'b0;
`endif

    assign if_ack    = done_if;
    assign d_ack     = done_d;
    assign if_rdata  = done_if ? rdata_q : 32'h0;
    assign d_rdata   = done_d ? rdata_q : 32'h0;
    assign mem_en    = (state == ACCESS);
    assign mem_rw    = !((state == ACCESS) && !rw_q);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: big-endian byte memory model plus per-port
// scoreboards of expected read data and fault flags.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int WAIT   = 2;
    localparam int BUDGET = 40;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [1:0]  if_size = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_fault;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b1;
    logic [31:0] d_addr = '0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_fault;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_size(if_size),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_fault(if_fault),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_fault(d_fault),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            16'h10:  return 8'hDE;
            16'h11:  return 8'hAD;
            16'h12:  return 8'hBE;
            16'h13:  return 8'hEF;
            default: return 8'(32'h40 + i);
        endcase
    endfunction

    // Memory: right-justified, big-endian data; invalid pattern outside read enables.
    always_comb begin
        int a;
        a = int'(mem_addr[7:0]);
        mem_rdata = 32'h5A5A_5A5A;
        if (mem_en === 1'b1 && mem_rw === 1'b1) begin
            case (mem_size)
                2'b01:   mem_rdata = {16'b0, mem[a], mem[(a + 1) % 256]};
                2'b10:   mem_rdata = {mem[a], mem[(a + 1) % 256], mem[(a + 2) % 256], mem[(a + 3) % 256]};
                2'b11:   mem_rdata = 32'hBAD0_BAD0;
                default: mem_rdata = {24'b0, mem[a]};
            endcase
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1 && mem_rw === 1'b0) begin
                case (mem_size)
                    2'b01: begin
                        mem[mem_addr[7:0]]        = mem_wdata[15:8];
                        mem[mem_addr[7:0] + 8'd1] = mem_wdata[7:0];
                    end
                    2'b10: begin
                        mem[mem_addr[7:0]]        = mem_wdata[31:24];
                        mem[mem_addr[7:0] + 8'd1] = mem_wdata[23:16];
                        mem[mem_addr[7:0] + 8'd2] = mem_wdata[15:8];
                        mem[mem_addr[7:0] + 8'd3] = mem_wdata[7:0];
                    end
                    default: mem[mem_addr[7:0]] = mem_wdata[7:0];
                endcase
            end
        end
    end

    exp_t       exp_if[$];
    exp_t       exp_d[$];
    int         ack_log[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_on = 1'b0;
    int         en_count = 0;
    int         rw_low = 0;
    int         rw_low_no_en = 0;
    int         hyg_bad = 0;
    logic [1:0] last_en_size = 2'b00;

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
        int i;
        i = int'(a[7:0]);
        case (s)
            2'b01:   return {16'b0, ref_mem[i], ref_mem[i + 1]};
            2'b10:   return {ref_mem[i], ref_mem[i + 1], ref_mem[i + 2], ref_mem[i + 3]};
            default: return {24'b0, ref_mem[i]};
        endcase
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        int i;
        i = int'(a[7:0]);
        case (s)
            2'b01: begin
                ref_mem[i] = wd[15:8]; ref_mem[i + 1] = wd[7:0];
            end
            2'b10: begin
                ref_mem[i] = wd[31:24]; ref_mem[i + 1] = wd[23:16];
                ref_mem[i + 2] = wd[15:8]; ref_mem[i + 3] = wd[7:0];
            end
            default: ref_mem[i] = wd[7:0];
        endcase
    endfunction

    function automatic logic ref_fault(input logic [31:0] a, input logic [1:0] s);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        return ((s == 2'b01) && a[0]) || ((s == 2'b10) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // One clock: advance past the edge, then observe outputs and score any ack.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (!mon_on) return;
        if (mem_en === 1'b1) begin
            en_count++;
            last_en_size = mem_size;
        end
        if (mem_rw !== 1'b1) begin
            rw_low++;
            if (mem_en !== 1'b1) rw_low_no_en++;
        end
        if ((if_ack !== 1'b1 && (if_rdata !== 32'h0 || if_fault !== 1'b0)) ||
            (d_ack !== 1'b1 && (d_rdata !== 32'h0 || d_fault !== 1'b0)) ||
            (if_ack === 1'b1 && d_ack === 1'b1) || (busy !== 1'b1 && mem_en !== 1'b0))
            hyg_bad++;
        if (if_ack === 1'b1) begin
            ack_log.push_back(0);
            checks++;
            if (exp_if.size() == 0) begin
                failures++;
                $display("FAIL if_unexpected_ack: got ack rdata=%h, expected no ack", if_rdata);
            end else begin
                e = exp_if.pop_front();
                if (if_rdata !== e.rdata || if_fault !== e.fault) begin
                    failures++;
                    $display("FAIL if_scoreboard: got rdata=%h fault=%b, expected rdata=%h fault=%b",
                             if_rdata, if_fault, e.rdata, e.fault);
                end
            end
        end
        if (d_ack === 1'b1) begin
            ack_log.push_back(1);
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL d_unexpected_ack: got ack rdata=%h, expected no ack", d_rdata);
            end else begin
                e = exp_d.pop_front();
                if (d_rdata !== e.rdata || d_fault !== e.fault) begin
                    failures++;
                    $display("FAIL d_scoreboard: got rdata=%h fault=%b, expected rdata=%h fault=%b",
                             d_rdata, d_fault, e.rdata, e.fault);
                end
            end
        end
    endtask

    task automatic issue_if(input logic [31:0] a, input logic [1:0] s);
        exp_t e;
        e.fault = ref_fault(a, s);
        e.rdata = e.fault ? 32'h0 : ref_read(a, s);
        exp_if.push_back(e);
        if_addr = a;
        if_size = s;
        if_req  = 1'b1;
    endtask

    task automatic issue_d(input logic rw, input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        exp_t e;
        e.fault = ref_fault(a, s);
        if (rw) begin
            e.rdata = e.fault ? 32'h0 : ref_read(a, s);
        end else begin
            e.rdata = 32'h0;
            if (!e.fault) ref_write(a, s, wd);
        end
        exp_d.push_back(e);
        d_rw    = rw;
        d_addr  = a;
        d_size  = s;
        d_wdata = wd;
        d_req   = 1'b1;
    endtask

    task automatic wait_ack(input bit port, output int edges);
        edges = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            step();
            if ((port ? d_ack : if_ack) === 1'b1) begin
                edges = i;
                if (port) d_req = 1'b0; else if_req = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_ack: port %0d got no ack in %0d cycles, expected an ack", port, BUDGET);
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    task automatic run_both(input int n, output int cyc);
        int nf, nd;
        nf = 0; nd = 0; cyc = 0;
        while ((nf < n || nd < n) && cyc < BUDGET * 2 * n) begin
            step();
            cyc++;
            if (if_ack === 1'b1) begin nf++; if (nf >= n) if_req = 1'b0; end
            if (d_ack === 1'b1) begin nd++; if (nd >= n) d_req = 1'b0; end
        end
        checks++;
        if (nf != n || nd != n) begin
            failures++;
            $display("FAIL run_both: got fetch=%0d data=%0d acks, expected %0d each", nf, nd, n);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({if_ack, d_ack, if_fault, d_fault, busy, mem_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {if_ack, d_ack, if_fault, d_fault, busy, mem_en});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h/%h, expected 0/0", if_rdata, d_rdata);
        end
        checks++;
        if (mem_rw !== 1'b1) begin
            failures++;
            $display("FAIL reset_mem_rw: got %b, expected 1", mem_rw);
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_size} !== 66'h0) begin
            failures++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h size=%b, expected zeros",
                     mem_addr, mem_wdata, mem_size);
        end
        reset  = 1'b0;
        mon_on = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_fetch_word();
        int edges, en0;
        en0 = en_count;
        issue_if(32'h10, 2'b10);
        wait_ack(1'b0, edges);
        checks++;
        if (edges != WAIT + 2) begin
            failures++;
            $display("FAIL fetch_latency: got %0d edges, expected %0d", edges, WAIT + 2);
        end
        checks++;
        if (if_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL fetch_rdata: got %h, expected deadbeef", if_rdata);
        end
        checks++;
        if (en_count - en0 != WAIT) begin
            failures++;
            $display("FAIL fetch_en_cycles: got %0d, expected %0d", en_count - en0, WAIT);
        end
    endtask

    task automatic test_write_then_read();
        int edges, rl0, rn0;
        step();
        rl0 = rw_low;
        rn0 = rw_low_no_en;
        issue_d(1'b0, 32'h20, 2'b01, 32'h0000_ABCD);
        wait_ack(1'b1, edges);
        checks++;
        if (edges != WAIT + 2) begin
            failures++;
            $display("FAIL write_latency: got %0d edges, expected %0d", edges, WAIT + 2);
        end
        checks++;
        if (rw_low - rl0 != WAIT || rw_low_no_en - rn0 != 0) begin
            failures++;
            $display("FAIL write_rw_window: got %0d low cycles (%0d outside en), expected %0d (0)",
                     rw_low - rl0, rw_low_no_en - rn0, WAIT);
        end
        checks++;
        if ({mem[8'h20], mem[8'h21]} !== 16'hABCD) begin
            failures++;
            $display("FAIL write_mem: got %h%h, expected abcd", mem[8'h20], mem[8'h21]);
        end
        step();
        issue_d(1'b1, 32'h21, 2'b00, 32'h0);
        wait_ack(1'b1, edges);
        checks++;
        if (d_rdata !== 32'h0000_00CD) begin
            failures++;
            $display("FAIL byte_read: got %h, expected 000000cd", d_rdata);
        end
    endtask

    task automatic test_round_robin();
        int cyc, log0;
        step();
        log0 = ack_log.size();
        for (int k = 0; k < 3; k++) begin
            issue_if(32'h10, 2'b10);
            issue_d(1'b1, 32'h12, 2'b01, 32'h0);
        end
        run_both(3, cyc);
        checks++;
        if (ack_log.size() - log0 != 6) begin
            failures++;
            $display("FAIL rr_count: got %0d acks, expected 6", ack_log.size() - log0);
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (ack_log[log0 + k] != (k % 2)) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got port %0d, expected port %0d",
                             k, ack_log[log0 + k], k % 2);
                end
            end
        end
        checks++;
        if (cyc != WAIT + 2 + 5 * (WAIT + 3)) begin
            failures++;
            $display("FAIL rr_throughput: got %0d cycles, expected %0d", cyc, WAIT + 2 + 5 * (WAIT + 3));
        end
    endtask

    task automatic test_size11();
        int edges;
        step();
        issue_d(1'b1, 32'h10, 2'b11, 32'h0);
        wait_ack(1'b1, edges);
        checks++;
        if (d_rdata !== 32'h0000_00DE) begin
            failures++;
            $display("FAIL size11_rdata: got %h, expected 000000de", d_rdata);
        end
        checks++;
        if (last_en_size !== 2'b00) begin
            failures++;
            $display("FAIL size11_mem_size: got %b, expected 00", last_en_size);
        end
    endtask

    task automatic test_align();
        int edges, en0, exp_edges, exp_en;
        logic exp_fault;
`ifdef MEM_ARB_ALIGN_CHECK_EN
        exp_edges = 1; exp_en = 0; exp_fault = 1'b1;
`else
        exp_edges = WAIT + 2; exp_en = WAIT; exp_fault = 1'b0;
`endif
        step();
        en0 = en_count;
        issue_d(1'b1, 32'h02, 2'b10, 32'h0);
        wait_ack(1'b1, edges);
        checks++;
        if (edges != exp_edges) begin
            failures++;
            $display("FAIL align_latency: got %0d edges, expected %0d", edges, exp_edges);
        end
        checks++;
        if (d_fault !== exp_fault) begin
            failures++;
            $display("FAIL align_fault: got %b, expected %b", d_fault, exp_fault);
        end
        checks++;
        if (en_count - en0 != exp_en) begin
            failures++;
            $display("FAIL align_en_cycles: got %0d, expected %0d", en_count - en0, exp_en);
        end
    endtask

    task automatic test_reset_mid_access();
        int edges, cyc, log0;
        exp_t dropped;
        step();
        issue_if(32'h04, 2'b10);
        wait_ack(1'b0, edges);
        step();
        issue_if(32'h08, 2'b10);
        repeat (3) step();
        checks++;
        if (mem_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_access: got mem_en=%b busy=%b, expected 1/1", mem_en, busy);
        end
        reset  = 1'b1;
        if_req = 1'b0;
        step();
        checks++;
        if ({mem_en, busy, if_ack} !== 3'b000) begin
            failures++;
            $display("FAIL abort_reset: got mem_en=%b busy=%b if_ack=%b, expected 000",
                     mem_en, busy, if_ack);
        end
        if (exp_if.size() > 0) dropped = exp_if.pop_back();
        reset = 1'b0;
        repeat (2) step();
        log0 = ack_log.size();
        issue_if(32'h10, 2'b10);
        issue_d(1'b1, 32'h11, 2'b00, 32'h0);
        run_both(1, cyc);
        checks++;
        if (ack_log.size() <= log0 || ack_log[log0] != 0) begin
            failures++;
            $display("FAIL post_reset_tie: got first grant port %0d, expected port 0",
                     (ack_log.size() > log0) ? ack_log[log0] : -1);
        end
    endtask

    task automatic test_final();
        repeat (2) step();
        checks++;
        if (exp_if.size() != 0 || exp_d.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", exp_if.size(), exp_d.size());
        end
        checks++;
        if (hyg_bad != 0) begin
            failures++;
            $display("FAIL output_hygiene: got %0d bad cycles, expected 0", hyg_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        test_reset();
        test_fetch_word();
        test_write_then_read();
        test_round_robin();
        test_size11();
        test_align();
        test_reset_mid_access();
        test_final();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and access sequencer for the byte-addressed `memory_unit`. It shares the single memory between the CPU instruction-fetch port and the data (load/store) port. Arbitration is round-robin. Each granted request becomes a fixed-length Enable/ReadWrite/wordSelector access. Sits between the fetch/datapath control logic and `memory_unit`, and returns read data zero-extended per access size.

## Interface
- `WAIT_CYCLES`, default 2: cycles `mem_en` is held high per access; legal range 1..15.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held with fields stable until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as byte.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_rdata`  out  32  fetch read data; valid while `if_ack`=1.
- `if_fault`  out  1  alignment fault; valid while `if_ack`=1.
- `d_req`  in  1  data request; same hold rule as `if_req`.
- `d_rw`  in  1  1 = read, 0 = write (same polarity as memory ReadWrite).
- `d_addr`  in  32  data byte address.
- `d_size`  in  2  same encoding as `if_size`.
- `d_wdata`  in  32  store data, right-justified.
- `d_ack`, `d_rdata`, `d_fault`  out  1/32/1  same meaning as fetch-side outputs.
- `mem_en`  out  1  to memory Enable.
- `mem_rw`  out  1  to memory ReadWrite.
- `mem_addr`  out  32  to memory Address.
- `mem_wdata`  out  32  to memory DataIn.
- `mem_size`  out  2  to memory wordSelector.
- `mem_rdata`  in  32  from memory DataOut.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM has four states: IDLE, SETUP, ACCESS, DONE.
- **IDLE:** requests are sampled here only.
  - One request pending: grant it.
  - Both pending: grant the port not granted last (`last_grant` register).
  - Neither pending: stay in IDLE.
  - On grant, latch addr/size/rw/wdata into internal registers and go to SETUP. A fetch grant always latches rw=1.
- **SETUP (1 cycle):** drive `mem_addr`, `mem_wdata`, `mem_size` and `mem_rw` from the latched values, with `mem_en`=0. Go to ACCESS and load wait counter = `WAIT_CYCLES`-1.
- **ACCESS:** `mem_en`=1, all other mem outputs held stable. Decrement the counter. When the counter is 0 and the access is a read, capture the read data, then go to DONE.
- **DONE (1 cycle):**
  - `mem_en`=0 and `mem_rw`=1.
  - Granted port gets ack=1; its rdata and fault are valid.
  - Update `last_grant` to the granted port, then return to IDLE.
- Read data is zero-extended:
  - byte → `{24'b0, mem_rdata[7:0]}`
  - halfword → `{16'b0, mem_rdata[15:0]}`
  - word → full `mem_rdata`
- Writes return rdata = 0.
- Size 11 is normalized to 00 on `mem_size`.
- Outside ACCESS: `mem_rw`=1 and `mem_en`=0. Combinational, glitch-free decode from registered state, so the memory never sees a spurious write.
- Non-granted port ack, fault and rdata stay 0.
- A requester still holding req in the cycle after its ack is treated as a new request.

## Timing
- Reset values:
  - all acks, faults, `mem_en`, `busy` = 0
  - rdata buses = 0
  - `mem_rw` = 1
  - `mem_addr`, `mem_wdata`, `mem_size` = 0
  - state = IDLE
  - `last_grant` = data, so fetch wins the first tie.
- Latency: request sampled at edge n → ack high in cycle n+`WAIT_CYCLES`+1.
  - Cycle n: SETUP.
  - Cycles n+1 to n+`WAIT_CYCLES`: ACCESS.
- Back-to-back throughput: one access per `WAIT_CYCLES`+3 cycles.
- Requests arriving while busy are not sampled; they wait in the requester with req held.
- Reset asserted mid-access: next edge forces IDLE and `mem_en`=0. No ack is issued for the aborted access; any partial write is not rolled back.
- `mem_rdata` is sampled only on the last ACCESS cycle.

## Configuration
- `MEM_ARB_ALIGN_CHECK_EN` defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, is faulted.
  - The grant goes IDLE→DONE directly; `mem_en` never rises.
  - Ack is asserted with fault=1 and rdata=0; latency is 1 cycle.
  - `last_grant` still updates.
- Not defined: unaligned accesses pass through unchanged, and `if_fault`/`d_fault` are tied 0.

## Test plan
- Reset, then fetch word at 0x10 with memory bytes 0x10..0x13 = DE AD BE EF, WAIT=2 → `if_ack` in cycle 3 after sampling, `if_rdata`=0xDEADBEEF, `mem_en` high exactly 2 cycles.
- Data halfword write 0xABCD to 0x20, then byte read at 0x21 → `d_rdata`=0x000000CD, `mem_rw`=0 only during the write's ACCESS cycles.
- `if_req` and `d_req` asserted together, held continuously for 3 accesses each → grants alternate fetch, data, fetch, data…; neither port waits more than one access.
- Reset asserted in the 2nd ACCESS cycle of a fetch → next cycle `mem_en`=0, `busy`=0, no `if_ack`. Then a simultaneous request → fetch granted first.
- With `MEM_ARB_ALIGN_CHECK_EN`, data word read at 0x02 → `d_ack`=1 with `d_fault`=1 one cycle after grant, `mem_en` stays 0. Without the macro → normal access, `d_fault`=0.
- Data read with size 11 at 0x10 → `mem_size`=00, `d_rdata`=0x000000DE.
